// File: rtl/dpram_arb_if.sv
// Requester, response and RAM-side bundle for dpram_arb.
// master = requesters plus RAM model, slave = the arbiter.
interface dpram_arb_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 4
);
  logic             req0, lock0, we0, gnt0;
  logic [ADDR-1:0]  addr0;
  logic [WIDTH-1:0] wdata0;
  logic             req1, lock1, we1, gnt1;
  logic [ADDR-1:0]  addr1;
  logic [WIDTH-1:0] wdata1;

  logic             rsp_valid, rsp_id;
  logic [WIDTH-1:0] rsp_data;

  logic             ram_wr_en, ram_rd_en;
  logic [ADDR-1:0]  ram_wr_addr, ram_rd_addr;
  logic [WIDTH-1:0] ram_wr_data, ram_rd_data;

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    input  gnt0, gnt1, rsp_valid, rsp_id, rsp_data,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
    output ram_rd_data
  );

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    output gnt0, gnt1, rsp_valid, rsp_id, rsp_data,
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
    input  ram_rd_data
  );
endinterface

// File: rtl/dpram_arb.sv
// Two-requester RAM arbiter, round-robin with optional locked bursts (DPRAM_ARB_LOCK_EN).
// Grant is combinational, read response 1 cycle later; a losing requester simply stalls.
module dpram_arb #(
  parameter int WIDTH    = 32,
  parameter int ADDR     = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  dpram_arb_if.slave  bus
);
  logic             prio, prio_nxt;
  logic             gnt_vld, gnt_id, gnt_we;
  logic [ADDR-1:0]  gnt_addr;
  logic [WIDTH-1:0] gnt_wdata;

`ifdef DPRAM_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  state_t     state, state_nxt;
  logic [7:0] lock_cnt, cnt_nxt;
  logic       locked_path, gnt_lock;
`else
  logic       unused_lock;
  assign unused_lock = bus.lock0 ^ bus.lock1;
`endif

  always_comb begin
    gnt_vld = bus.req0 | bus.req1;
    gnt_id  = (bus.req0 & bus.req1) ? prio : bus.req1;
`ifdef DPRAM_ARB_LOCK_EN
    // An owner that still holds its lock keeps the RAM; the other side waits.
    locked_path = ((state == OWN0) && bus.lock0) || ((state == OWN1) && bus.lock1);
    if (locked_path) begin
      gnt_id  = (state == OWN1);
      gnt_vld = gnt_id ? bus.req1 : bus.req0;
    end
`endif
    if (rst) gnt_vld = 1'b0;
  end

  always_comb begin
    gnt_we    = gnt_id ? bus.we1    : bus.we0;
    gnt_addr  = gnt_id ? bus.addr1  : bus.addr0;
    gnt_wdata = gnt_id ? bus.wdata1 : bus.wdata0;
  end

  assign bus.gnt0        = gnt_vld & ~gnt_id;
  assign bus.gnt1        = gnt_vld &  gnt_id;
  assign bus.ram_wr_en   = gnt_vld &  gnt_we;
  assign bus.ram_rd_en   = gnt_vld & ~gnt_we;
  assign bus.ram_wr_addr = gnt_addr;
  assign bus.ram_wr_data = gnt_wdata;
  assign bus.ram_rd_addr = gnt_addr;
  assign bus.rsp_data    = bus.ram_rd_data;

  assign prio_nxt = gnt_vld ? ~gnt_id : prio;

`ifdef DPRAM_ARB_LOCK_EN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    gnt_lock  = gnt_id ? bus.lock1 : bus.lock0;
    if (locked_path) begin
      if (gnt_vld) begin
        // Burst cap reached: hand back to arbitration so the other side gets a turn.
        if (lock_cnt + 8'd1 == MAX_LOCK_C) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt   = lock_cnt + 8'd1;
        end
      end
    end else if (gnt_vld && gnt_lock) begin
      state_nxt = gnt_id ? OWN1 : OWN0;
      cnt_nxt   = 8'd1;
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = 8'd0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prio          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
`ifdef DPRAM_ARB_LOCK_EN
      state         <= IDLE;
      lock_cnt      <= 8'd0;
`endif
    end else begin
      prio          <= prio_nxt;
      bus.rsp_valid <= gnt_vld & ~gnt_we;
      bus.rsp_id    <= gnt_id;
`ifdef DPRAM_ARB_LOCK_EN
      state         <= state_nxt;
      lock_cnt      <= cnt_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_dpram_arb.sv
// Directed bench for dpram_arb with a registered-read RAM model on clk.
module tb_dpram_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  dpram_arb_if #(.WIDTH(32), .ADDR(4)) bus ();

  dpram_arb #(.WIDTH(32), .ADDR(4), .MAX_LOCK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  logic [1:0] g;
  assign g = {bus.gnt1, bus.gnt0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.lock0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.lock1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0 = 1; bus.req1 = 1; bus.we0 = 1; bus.we1 = 0;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (g !== 2'b00) $display("FAIL reset_gnt got %b want 00", g); else passed++;
    total++;
    if ({bus.ram_wr_en, bus.ram_rd_en} !== 2'b00)
      $display("FAIL reset_ram_en got %b%b want 00", bus.ram_wr_en, bus.ram_rd_en); else passed++;
    total++;
    if ({bus.rsp_valid, bus.rsp_id} !== 2'b00)
      $display("FAIL reset_rsp got %b%b want 00", bus.rsp_valid, bus.rsp_id); else passed++;
    total++;
    if (dut.prio !== 1'b0) $display("FAIL reset_prio got %b want 0", dut.prio); else passed++;
    tick();
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_write_read();
    do_reset();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd3; bus.wdata0 = 32'hA5A5_A5A5;
    @(negedge clk);
    total++;
    if (g !== 2'b01) $display("FAIL wr_gnt got %b want 01", g); else passed++;
    total++;
    if ({bus.ram_wr_en, bus.ram_rd_en, bus.ram_wr_addr, bus.ram_wr_data} !== {2'b10, 4'd3, 32'hA5A5_A5A5})
      $display("FAIL wr_ram got en=%b%b a=%0d d=%h want en=10 a=3 d=a5a5a5a5",
               bus.ram_wr_en, bus.ram_rd_en, bus.ram_wr_addr, bus.ram_wr_data); else passed++;
    tick();
    idle_inputs();
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd3;
    @(negedge clk);
    total++;
    if (g !== 2'b10) $display("FAIL rd_gnt got %b want 10", g); else passed++;
    total++;
    if ({bus.ram_wr_en, bus.ram_rd_en, bus.ram_rd_addr} !== {2'b01, 4'd3})
      $display("FAIL rd_ram got en=%b%b a=%0d want en=01 a=3",
               bus.ram_wr_en, bus.ram_rd_en, bus.ram_rd_addr); else passed++;
    total++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL wr_no_rsp got %b want 0", bus.rsp_valid); else passed++;
    tick();
    // Also seed address 5 from requester 1 for the back-to-back test.
    idle_inputs();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'd5; bus.wdata1 = 32'h5A5A_0F0F;
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {2'b11, 32'hA5A5_A5A5})
      $display("FAIL rd_rsp got v=%b id=%b d=%h want v=1 id=1 d=a5a5a5a5",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data); else passed++;
    total++;
    if (g !== 2'b10) $display("FAIL wr1_gnt got %b want 10", g); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req0 = 1; bus.addr0 = 4'd3;
    bus.req1 = 1; bus.addr1 = 4'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL b2b_gnt[%0d] got %b want %b", i, g, (i % 2 == 0) ? 2'b01 : 2'b10); else passed++;
      if (i > 0) begin
        total++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !==
            {1'b1, 1'((i - 1) % 2), ((i - 1) % 2 == 1) ? 32'h5A5A_0F0F : 32'hA5A5_A5A5})
          $display("FAIL b2b_rsp[%0d] got v=%b id=%b d=%h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        else passed++;
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {2'b11, 32'h5A5A_0F0F})
      $display("FAIL b2b_last_rsp got v=%b id=%b d=%h want v=1 id=1 d=5a5a0f0f",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data); else passed++;
    tick();
  endtask

`ifdef DPRAM_ARB_LOCK_EN
  task automatic test_lock_burst();
    logic [1:0] exp;
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 4'd3;
    bus.req1 = 1; bus.lock1 = 0; bus.addr1 = 4'd5;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      exp = (i == 8) ? 2'b10 : 2'b01;
      total++;
      if (g !== exp) $display("FAIL lock_gnt[%0d] got %b want %b", i, g, exp); else passed++;
      if (i == 8 || i == 10) begin
        total++;
        if (dut.lock_cnt !== ((i == 8) ? 8'd0 : 8'd1))
          $display("FAIL lock_cnt[%0d] got %0d want %0d", i, dut.lock_cnt, (i == 8) ? 0 : 1);
        else passed++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock_drop();
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.req1 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (g !== 2'b01) $display("FAIL drop_gnt[%0d] got %b want 01", i, g); else passed++;
      tick();
    end
    bus.lock0 = 0;
    @(negedge clk);
    total++;
    if (g !== 2'b10) $display("FAIL drop_gnt1 got %b want 10", g); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_lock_hold();
    do_reset();
    bus.req0 = 1; bus.lock0 = 1;
    tick();
    bus.req0 = 0; bus.req1 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (g !== 2'b00) $display("FAIL hold_gnt[%0d] got %b want 00", i, g); else passed++;
      total++;
      if (dut.lock_cnt !== 8'd1) $display("FAIL hold_cnt[%0d] got %0d want 1", i, dut.lock_cnt); else passed++;
      tick();
    end
    bus.req0 = 1;
    @(negedge clk);
    total++;
    if (g !== 2'b01) $display("FAIL hold_resume got %b want 01", g); else passed++;
    tick();
    @(negedge clk);
    total++;
    if (dut.lock_cnt !== 8'd2) $display("FAIL hold_cnt2 got %0d want 2", dut.lock_cnt); else passed++;
    idle_inputs();
    tick();
  endtask
`else
  task automatic test_no_lock();
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 4'd3;
    bus.req1 = 1; bus.lock1 = 0; bus.addr1 = 4'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL nolock_gnt[%0d] got %b want %b", i, g, (i % 2 == 0) ? 2'b01 : 2'b10); else passed++;
      tick();
    end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.we0 = 0; bus.addr0 = 4'd3;
    @(negedge clk);
    total++;
    if (g !== 2'b01) $display("FAIL mid_gnt got %b want 01", g); else passed++;
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (g !== 2'b00) $display("FAIL mid_rst_gnt got %b want 00", g); else passed++;
    tick();
    rst = 1'b0;
    bus.req0 = 0; bus.lock0 = 1; bus.req1 = 1;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rsp got %b want 0", bus.rsp_valid); else passed++;
    total++;
    if (dut.prio !== 1'b0) $display("FAIL mid_prio got %b want 0", dut.prio); else passed++;
    total++;
    if (g !== 2'b10) $display("FAIL mid_idle_gnt got %b want 10", g); else passed++;
`ifdef DPRAM_ARB_LOCK_EN
    total++;
    if (dut.lock_cnt !== 8'd0) $display("FAIL mid_cnt got %0d want 0", dut.lock_cnt); else passed++;
`endif
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_back_to_back();
`ifdef DPRAM_ARB_LOCK_EN
    test_lock_burst();
    test_lock_drop();
    test_lock_hold();
`else
    test_no_lock();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
